// File: rtl/alu_mdu_pkg.sv
// ALU op codes shared by the controller, the ALU and the multiply/divide engine.
package alu_mdu_pkg;

    localparam logic [3:0] ALU_NOP   = 4'd0;
    localparam logic [3:0] ALU_ADD   = 4'd1;
    localparam logic [3:0] ALU_SUB   = 4'd2;
    localparam logic [3:0] ALU_AND   = 4'd3;
    localparam logic [3:0] ALU_OR    = 4'd4;
    localparam logic [3:0] ALU_SLT   = 4'd5;
    localparam logic [3:0] ALU_SLTU  = 4'd6;
    localparam logic [3:0] ALU_XOR   = 4'd7;
    localparam logic [3:0] ALU_NOR   = 4'd8;
    localparam logic [3:0] ALU_SLL   = 4'd9;
    localparam logic [3:0] ALU_SRL   = 4'd10;
    localparam logic [3:0] ALU_SRA   = 4'd11;
    localparam logic [3:0] ALU_MULT  = 4'd12;
    localparam logic [3:0] ALU_MULTU = 4'd13;
    localparam logic [3:0] ALU_DIV   = 4'd14;
    localparam logic [3:0] ALU_DIVU  = 4'd15;

    function automatic logic op_is_mul(input logic [3:0] op);
        return (op == ALU_MULT) || (op == ALU_MULTU);
    endfunction

    function automatic logic op_is_div(input logic [3:0] op);
        return (op == ALU_DIV) || (op == ALU_DIVU);
    endfunction

    function automatic logic op_is_signed(input logic [3:0] op);
        return (op == ALU_MULT) || (op == ALU_DIV);
    endfunction

endpackage

// File: rtl/alu_mdu_if.sv
// Execute-stage operand/result bundle between the controller (master) and alu_mdu (slave).
interface alu_mdu_if #(
    parameter int WIDTH = 32
) ();
    logic [WIDTH-1:0]         A;
    logic [WIDTH-1:0]         B;
    logic [$clog2(WIDTH)-1:0] shamt;
    logic [3:0]               ALUOp;
    logic                     start;
    logic [WIDTH-1:0]         C;
    logic                     Zero;
    logic [WIDTH-1:0]         HI;
    logic [WIDTH-1:0]         LO;
    logic                     busy;
    logic                     done;

    modport master (
        output A, B, shamt, ALUOp, start,
        input  C, Zero, HI, LO, busy, done
    );

    modport slave (
        input  A, B, shamt, ALUOp, start,
        output C, Zero, HI, LO, busy, done
    );
endinterface

// File: rtl/mdu_iter.sv
// Iterative multiply/divide engine (divider only with ALU_MDU_DIV_EN) writing HI/LO.
// Latency: WIDTH+1 cycles from the start edge to done; without the divider DIV/DIVU done after 1.
// Backpressure: none; start is ignored while busy, the controller stalls on busy.
module mdu_iter
    import alu_mdu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNTW  = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    logic [1:0]         state;
    logic [CNTW-1:0]    cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opb;
    logic               neg_res;

    logic               is_signed;
    logic [WIDTH-1:0]   ua;
    logic [WIDTH-1:0]   ub;
    logic               mul_go;
    logic               div_go;
    logic               launch;
    logic               div_skip;

    logic [WIDTH:0]     msum;
    logic [2*WIDTH-1:0] mul_next;

    assign is_signed = op_is_signed(op);
    assign ua        = (is_signed && a[WIDTH-1]) ? -a : a;
    assign ub        = (is_signed && b[WIDTH-1]) ? -b : b;
    assign mul_go    = start && (state == S_IDLE) && op_is_mul(op);
    assign div_go    = start && (state == S_IDLE) && op_is_div(op);

    // acc = {partial product, remaining multiplier}; one multiplier bit retires per cycle
    assign msum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
    assign mul_next = {msum, acc[WIDTH-1:1]};

`ifdef ALU_MDU_DIV_EN
    logic               is_div;
    logic               neg_rem;
    logic               dz;
    logic [WIDTH:0]     dsh;
    logic               dge;
    logic [WIDTH-1:0]   drem;
    logic [2*WIDTH-1:0] div_next;

    // acc = {partial remainder, dividend bits shifting out / quotient bits shifting in}
    assign dsh      = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign dge      = (dsh >= {1'b0, opb});
    assign drem     = dsh[WIDTH-1:0] - opb;
    assign div_next = {(dge ? drem : dsh[WIDTH-1:0]), acc[WIDTH-2:0], dge};

    assign launch   = mul_go || div_go;
    assign div_skip = 1'b0;
`else
    assign launch   = mul_go;
    assign div_skip = div_go;
`endif

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= S_IDLE;
            cnt     <= '0;
            acc     <= '0;
            opb     <= '0;
            neg_res <= 1'b0;
            done    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
`ifdef ALU_MDU_DIV_EN
            is_div  <= 1'b0;
            neg_rem <= 1'b0;
            dz      <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (launch) begin
                        state   <= S_CALC;
                        cnt     <= CNTW'(WIDTH);
                        acc     <= {{WIDTH{1'b0}}, ua};
                        opb     <= ub;
                        neg_res <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
`ifdef ALU_MDU_DIV_EN
                        is_div  <= div_go;
                        neg_rem <= is_signed && a[WIDTH-1];
                        dz      <= (b == '0);
`endif
                    end else if (div_skip) begin
                        done <= 1'b1;
                    end
                end
                S_CALC: begin
`ifdef ALU_MDU_DIV_EN
                    acc <= is_div ? div_next : mul_next;
`else
                    acc <= mul_next;
`endif
                    cnt <= cnt - 1'b1;
                    if (cnt == CNTW'(1)) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
`ifdef ALU_MDU_DIV_EN
                    // a zero divisor leaves |A| as remainder, so the sign fix restores HI = A
                    if (is_div) begin
                        lo <= dz ? '1 : (neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
                        hi <= neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
                    end else
`endif
                    begin
                        {hi, lo} <= neg_res ? -acc : acc;
                    end
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/alu_mdu.sv
// Execute-stage ALU: combinational single-cycle ops on C/Zero plus the mdu_iter HI/LO engine.
// Latency: C/Zero combinational; MULT/DIV results WIDTH+1 cycles after start (ALU_MDU_DIV_EN adds the divider).
// Backpressure: busy holds the controller in its EXE wait state; start while busy is dropped.
module alu_mdu
    import alu_mdu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNTW  = $clog2(WIDTH) + 1
) (
    input logic         clk,
    input logic         rstn,
    alu_mdu_if.slave    bus
);

    logic [WIDTH-1:0] c;

    // iterative and undefined codes pass A through so MFHI/MFLO-style paths see a stable C
    always_comb begin
        c = bus.A;
        case (bus.ALUOp)
            ALU_NOP:  c = bus.A;
            ALU_ADD:  c = bus.A + bus.B;
            ALU_SUB:  c = bus.A - bus.B;
            ALU_AND:  c = bus.A & bus.B;
            ALU_OR:   c = bus.A | bus.B;
            ALU_XOR:  c = bus.A ^ bus.B;
            ALU_NOR:  c = ~(bus.A | bus.B);
            ALU_SLT:  c = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
            ALU_SLTU: c = {{(WIDTH-1){1'b0}}, (bus.A < bus.B)};
            ALU_SLL:  c = bus.B << bus.shamt;
            ALU_SRL:  c = bus.B >> bus.shamt;
            ALU_SRA:  c = $unsigned($signed(bus.B) >>> bus.shamt);
            default:  c = bus.A;
        endcase
    end

    assign bus.C    = c;
    assign bus.Zero = (c == '0);

    mdu_iter #(
        .WIDTH (WIDTH),
        .CNTW  (CNTW)
    ) u_mdu_iter (
        .clk   (clk),
        .rstn  (rstn),
        .start (bus.start),
        .op    (bus.ALUOp),
        .a     (bus.A),
        .b     (bus.B),
        .busy  (bus.busy),
        .done  (bus.done),
        .hi    (bus.HI),
        .lo    (bus.LO)
    );

endmodule
